// File: rtl/rename_regfile_mp.sv
// Architectural register file with rename tags, NRD lookup ports and NCDB writeback ports.
// Optional macro RF_CDB_BYPASS_EN forwards matching CDB results to lookups in the same cycle.
module rename_regfile_mp #(
    parameter int  XLEN  = 32,
    parameter int  NREG  = 32,
    parameter int  TAG_W = 4,
    parameter int  NRD   = 2,
    parameter int  NCDB  = 2,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  issue_valid,
    input  logic [IDX_W-1:0]      issue_rd,
    input  logic [TAG_W-1:0]      issue_tag,
    input  logic [NRD*IDX_W-1:0]  rs_idx,
    output logic [NRD*XLEN-1:0]   rs_val,
    output logic [NRD*TAG_W-1:0]  rs_tag,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*IDX_W-1:0] cdb_rd,
    input  logic [NCDB*XLEN-1:0]  cdb_val
);

    logic [XLEN-1:0]  val_q [NREG];
    logic [TAG_W-1:0] tag_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [TAG_W-1:0] tag_d [NREG];

    logic [TAG_W-1:0] cdb_tag_a [NCDB];
    logic [IDX_W-1:0] cdb_rd_a  [NCDB];
    logic [XLEN-1:0]  cdb_val_a [NCDB];

    always_comb begin
        for (int c = 0; c < NCDB; c++) begin
            cdb_tag_a[c] = cdb_tag[c*TAG_W +: TAG_W];
            cdb_rd_a[c]  = cdb_rd[c*IDX_W +: IDX_W];
            cdb_val_a[c] = cdb_val[c*XLEN +: XLEN];
        end
    end

    // NOTE: every array element gets its hold value first, so partial updates below never infer latches.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            val_d[r] = val_q[r];
            tag_d[r] = tag_q[r];
        end
        // Ascending walk: a later (higher) port overwrites both value and tag decision.
        for (int c = 0; c < NCDB; c++) begin
            if (cdb_valid[c] && cdb_rd_a[c] != '0) begin
                val_d[cdb_rd_a[c]] = cdb_val_a[c];
                tag_d[cdb_rd_a[c]] = (tag_q[cdb_rd_a[c]] == cdb_tag_a[c]) ? '0 : tag_q[cdb_rd_a[c]];
            end
        end
        if (issue_valid && !flush_in && issue_rd != '0) begin
            tag_d[issue_rd] = issue_tag;
        end
        if (flush_in) begin
            for (int r = 0; r < NREG; r++) begin
                tag_d[r] = '0;
            end
        end
    end

    // NOTE: the file is reset as a whole because the rename state must be clean after reset; it is flops, not RAM.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
        end else if (rdy_in) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= val_d[r];
                tag_q[r] <= tag_d[r];
            end
        end
    end

    logic [IDX_W-1:0] rd_idx [NRD];
    logic [TAG_W-1:0] st_tag [NRD];
`ifdef RF_CDB_BYPASS_EN
    logic [NRD-1:0]   byp_hit;
    logic [XLEN-1:0]  byp_val [NRD];
`endif

    always_comb begin
        rs_val = '0;
        rs_tag = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_idx[p] = rs_idx[p*IDX_W +: IDX_W];
            st_tag[p] = tag_q[rd_idx[p]];
`ifdef RF_CDB_BYPASS_EN
            byp_hit[p] = 1'b0;
            byp_val[p] = '0;
            for (int c = 0; c < NCDB; c++) begin
                if (st_tag[p] != '0 && cdb_valid[c] && cdb_tag_a[c] == st_tag[p]) begin
                    byp_hit[p] = 1'b1;
                    byp_val[p] = cdb_val_a[c];
                end
            end
            rs_tag[p*TAG_W +: TAG_W] = byp_hit[p] ? '0 : st_tag[p];
            rs_val[p*XLEN +: XLEN]   = byp_hit[p] ? byp_val[p]
                                     : (st_tag[p] == '0 ? val_q[rd_idx[p]] : '0);
`else
            rs_tag[p*TAG_W +: TAG_W] = st_tag[p];
            rs_val[p*XLEN +: XLEN]   = (st_tag[p] == '0) ? val_q[rd_idx[p]] : '0;
`endif
        end
    end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Self-checking bench for rename_regfile_mp: directed scenarios then random traffic against a reference model.
module tb_rename_regfile_mp;
    localparam int XLEN = 32, NREG = 32, TAG_W = 4, NRD = 2, NCDB = 2, IDX_W = 5;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  rdy_in, flush_in, issue_valid;
    logic [IDX_W-1:0]      issue_rd;
    logic [TAG_W-1:0]      issue_tag;
    logic [NRD*IDX_W-1:0]  rs_idx;
    logic [NRD*XLEN-1:0]   rs_val;
    logic [NRD*TAG_W-1:0]  rs_tag;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*IDX_W-1:0] cdb_rd;
    logic [NCDB*XLEN-1:0]  cdb_val;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0]  m_val [NREG];
    logic [TAG_W-1:0] m_tag [NREG];

    rename_regfile_mp dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .rs_idx(rs_idx), .rs_val(rs_val), .rs_tag(rs_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_rd(cdb_rd), .cdb_val(cdb_val)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_val[r] = '0;
            m_tag[r] = '0;
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush_in = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_rd = '0; cdb_val = '0;
    endtask

    task automatic set_rs(input int p, input int idx);
        rs_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    task automatic set_cdb(input int c, input int tag, input int rd, input logic [31:0] v);
        cdb_valid[c] = 1'b1;
        cdb_tag[c*TAG_W +: TAG_W] = TAG_W'(tag);
        cdb_rd[c*IDX_W +: IDX_W]  = IDX_W'(rd);
        cdb_val[c*XLEN +: XLEN]   = v;
    endtask

    task automatic set_issue(input int rd, input int tag);
        issue_valid = 1'b1; issue_rd = IDX_W'(rd); issue_tag = TAG_W'(tag);
    endtask

    // Constant expectation on one read port (call shortly after inputs change).
    task automatic expect_rd(input string name, input int p, input logic [31:0] v, input logic [3:0] t);
        #1;
        check({name, "_val"}, rs_val[p*XLEN +: XLEN], v);
        check({name, "_tag"}, 32'(rs_tag[p*TAG_W +: TAG_W]), 32'(t));
    endtask

    // Check all read ports against the model, step one clock, update the model.
    task automatic cycle();
        logic [XLEN-1:0]  nv [NREG];
        logic [TAG_W-1:0] nt [NREG];
        #2;
        for (int p = 0; p < NRD; p++) begin
            int idx;
            logic [31:0] ev;
            logic [3:0]  et;
            idx = int'(rs_idx[p*IDX_W +: IDX_W]);
            et = m_tag[idx];
            ev = (et == 0) ? m_val[idx] : 32'h0;
`ifdef RF_CDB_BYPASS_EN
            if (et != 0) begin
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == et) begin
                        ev = cdb_val[c*XLEN +: XLEN];
                        et = 0;
                        break;
                    end
                end
            end
`endif
            check($sformatf("read%0d_x%0d_val", p, idx), rs_val[p*XLEN +: XLEN], ev);
            check($sformatf("read%0d_x%0d_tag", p, idx), 32'(rs_tag[p*TAG_W +: TAG_W]), 32'(et));
        end
        nv = m_val;
        nt = m_tag;
        if (rdy_in) begin
            for (int r = 1; r < NREG; r++) begin
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (cdb_valid[c] && int'(cdb_rd[c*IDX_W +: IDX_W]) == r) begin
                        nv[r] = cdb_val[c*XLEN +: XLEN];
                        if (m_tag[r] == cdb_tag[c*TAG_W +: TAG_W]) nt[r] = '0;
                        break;
                    end
                end
            end
            if (issue_valid && !flush_in && issue_rd != 0) nt[issue_rd] = issue_tag;
            if (flush_in) for (int r = 0; r < NREG; r++) nt[r] = '0;
        end
        @(posedge clk_in);
        #1;
        m_val = nv;
        m_tag = nt;
    endtask

    initial begin
        idle();
        rs_idx = '0;
        model_clear();
        set_rs(0, 5); set_rs(1, 9);
        #1 rst_in = 1'b0;
        expect_rd("reset0", 0, 32'h0, 4'h0);
        expect_rd("reset1", 1, 32'h0, 4'h0);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Rename then matching writeback.
        set_issue(5, 3); cycle();
        idle(); set_rs(0, 5); expect_rd("x5_pending", 0, 32'h0, 4'h3); cycle();
        set_cdb(0, 3, 5, 32'hDEAD); cycle();
        idle(); expect_rd("x5_written", 0, 32'hDEAD, 4'h0); cycle();

        // Stale producer must not clear a newer rename.
        set_issue(5, 3); cycle();
        set_issue(5, 7); cycle();
        idle(); set_cdb(0, 3, 5, 32'h11); cycle();
        idle(); expect_rd("x5_newer", 0, 32'h0, 4'h7); cycle();

        // Rename and writeback to the same register in one cycle.
        set_issue(6, 1); cycle();
        set_issue(6, 2); set_cdb(0, 1, 6, 32'h42); cycle();
        idle(); set_rs(1, 6); expect_rd("x6_rename_wins", 1, 32'h0, 4'h2); cycle();

        // Two ports hit x9; rename of x0 discarded.
        set_cdb(0, 5, 9, 32'hA); set_cdb(1, 6, 9, 32'hB); set_issue(0, 4); cycle();
        idle(); set_rs(0, 9); set_rs(1, 0);
        expect_rd("x9_hi_port", 0, 32'hB, 4'h0);
        expect_rd("x0_zero", 1, 32'h0, 4'h0);
        cycle();

        // Four pending tags, then flush with CDB writes.
        set_issue(10, 8); cycle();
        set_issue(11, 9); cycle();
        idle(); set_rs(0, 5); set_rs(1, 3);
        flush_in = 1'b1; set_issue(12, 4);
        set_cdb(0, 12, 3, 32'h77); set_cdb(1, 7, 5, 32'h55);
`ifdef RF_CDB_BYPASS_EN
        expect_rd("x5_bypass", 0, 32'h55, 4'h0);
`endif
        cycle();
        idle(); set_rs(0, 3); set_rs(1, 6);
        expect_rd("x3_flushwr", 0, 32'h77, 4'h0);
        expect_rd("x6_after_flush", 1, 32'h42, 4'h0);
        cycle();
        set_rs(0, 10); set_rs(1, 12); expect_rd("x10_flushed", 0, 32'h0, 4'h0); cycle();

        // Stall blocks every state change, flush included.
        set_issue(12, 5); cycle();
        rdy_in = 1'b0; flush_in = 1'b1; set_issue(13, 6); set_cdb(0, 5, 12, 32'h99); cycle();
        idle(); expect_rd("x12_stalled", 1, 32'h0, 4'h5); cycle();

        // Random traffic with collisions concentrated on x0..x7.
        for (int i = 0; i < 400; i++) begin
            idle();
            rdy_in   = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) set_issue($urandom_range(0, 7), $urandom_range(1, 15));
            for (int c = 0; c < NCDB; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int rd;
                    int tg;
                    rd = $urandom_range(0, 7);
                    tg = ($urandom_range(0, 1) == 1) ? int'(m_tag[rd]) : $urandom_range(0, 15);
                    set_cdb(c, tg, rd, $urandom);
                end
            end
            for (int p = 0; p < NRD; p++) set_rs(p, $urandom_range(0, 8));
            cycle();
        end

        // Asynchronous reset mid-run with renames pending.
        idle(); set_issue(4, 3); cycle();
        idle(); set_issue(7, 9); cycle();
        idle(); set_rs(0, 4); set_rs(1, 7);
        #1 rst_in = 1'b0;
        model_clear();
        expect_rd("midreset0", 0, 32'h0, 4'h0);
        expect_rd("midreset1", 1, 32'h0, 4'h0);
        #1 rst_in = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
